stage_cp_arb: RTL and testbench

//  Complete-stage result arbiter directly downstream of stage_ex. Buffers results from the
//  ALU0, ALU1 and MULT functional units in per-FU FIFOs and broadcasts at most one result per

---
 rtl/stage_cp_arb.sv | 133 +++++++++++++
 tb/tb_stage_cp_arb.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/stage_cp_arb.sv
// Complete-stage result arbiter: per-FU result FIFOs feeding a single registered CDB
// broadcast port, granted round-robin among FIFOs that were non-empty at cycle start.

module stage_cp_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 38,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [W-1:0]     wdata,
   output logic [W-1:0]     rdata,
   output logic [CNT_W-1:0] count
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] head, tail;

   // Payload storage carries no reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) mem[tail] <= wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (!push && pop) count <= count - 1'b1;
      end
   end

   assign rdata = mem[head];
endmodule

module stage_cp_arb #(
   parameter int NUM_FU = 3,
   parameter int DEPTH  = 2,
   parameter int TAG_W  = 5,
   parameter int XLEN   = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic [NUM_FU-1:0]       fu_valid,
   input  logic [NUM_FU*TAG_W-1:0] fu_tag,
   input  logic [NUM_FU*XLEN-1:0]  fu_value,
   input  logic [NUM_FU-1:0]       fu_take_branch,
   input  logic                    cdb_stall,
   output logic [NUM_FU-1:0]       fu_ready,
   output logic                    cdb_valid,
   output logic [TAG_W-1:0]        cdb_tag,
   output logic [XLEN-1:0]         cdb_value,
   output logic                    cdb_take_branch,
   output logic                    overflow_err
);
   localparam int FW    = 1 + TAG_W + XLEN;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int RR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

   logic [NUM_FU-1:0][FW-1:0]    wdata, rdata;
   logic [NUM_FU-1:0][CNT_W-1:0] count;
   logic [NUM_FU-1:0][RR_W-1:0]  cand;
   logic [NUM_FU-1:0]            push, pop, nonempty;
   logic [RR_W-1:0]              rr_ptr, gnt_idx;
   logic                         gnt_vld;

   for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fu
      assign wdata[gi]    = {fu_take_branch[gi], fu_tag[gi*TAG_W +: TAG_W], fu_value[gi*XLEN +: XLEN]};
      assign fu_ready[gi] = (count[gi] < CNT_W'(DEPTH));
      assign nonempty[gi] = (count[gi] != '0);
      // A full FIFO refuses the push even if it is popped on the same edge.
      assign push[gi]     = fu_valid[gi] & fu_ready[gi] & ~flush;
      assign pop[gi]      = gnt_vld & (gnt_idx == RR_W'(gi)) & ~flush;
      assign cand[gi]     = RR_W'((32'(rr_ptr) + gi) % NUM_FU);

      stage_cp_fifo #(.DEPTH(DEPTH), .W(FW), .CNT_W(CNT_W)) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .flush (flush),
         .push  (push[gi]),
         .pop   (pop[gi]),
         .wdata (wdata[gi]),
         .rdata (rdata[gi]),
         .count (count[gi])
      );
   end

   // Search order starts at rr_ptr; first non-empty FIFO wins.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         if (!gnt_vld && nonempty[cand[k]]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand[k];
         end
      end
      if (cdb_stall) gnt_vld = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr          <= '0;
         cdb_valid       <= 1'b0;
         cdb_tag         <= '0;
         cdb_value       <= '0;
         cdb_take_branch <= 1'b0;
         overflow_err    <= 1'b0;
      end else if (flush) begin
         cdb_valid <= 1'b0;
      end else begin
         if (|(fu_valid & ~fu_ready)) overflow_err <= 1'b1;
         cdb_valid <= gnt_vld;
         if (gnt_vld) begin
            {cdb_take_branch, cdb_tag, cdb_value} <= rdata[gnt_idx];
            rr_ptr <= (gnt_idx == RR_W'(NUM_FU - 1)) ? '0 : gnt_idx + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_stage_cp_arb.sv
// Directed bench for stage_cp_arb: stimulus pushes expected CDB results into a scoreboard,
// a negedge monitor pops and compares every broadcast.

module tb_stage_cp_arb;
   localparam int NUM_FU = 3;
   localparam int DEPTH  = 2;
   localparam int TAG_W  = 5;
   localparam int XLEN   = 32;

   typedef logic [TAG_W+XLEN:0] res_t;

   logic                    clk, rst, flush, cdb_stall;
   logic [NUM_FU-1:0]       fu_valid, fu_take_branch, fu_ready;
   logic [NUM_FU*TAG_W-1:0] fu_tag;
   logic [NUM_FU*XLEN-1:0]  fu_value;
   logic                    cdb_valid, cdb_take_branch, overflow_err;
   logic [TAG_W-1:0]        cdb_tag;
   logic [XLEN-1:0]         cdb_value;

   res_t sb[$];
   res_t exp_r;
   int   n_cmp = 0;
   int   n_err = 0;

   stage_cp_arb #(.NUM_FU(NUM_FU), .DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
      .clk             (clk),
      .rst             (rst),
      .flush           (flush),
      .fu_valid        (fu_valid),
      .fu_tag          (fu_tag),
      .fu_value        (fu_value),
      .fu_take_branch  (fu_take_branch),
      .cdb_stall       (cdb_stall),
      .fu_ready        (fu_ready),
      .cdb_valid       (cdb_valid),
      .cdb_tag         (cdb_tag),
      .cdb_value       (cdb_value),
      .cdb_take_branch (cdb_take_branch),
      .overflow_err    (overflow_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every broadcast must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst && cdb_valid) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_cdb: got tag %0d value %0h, expected no broadcast", cdb_tag, cdb_value);
         end else begin
            exp_r = sb.pop_front();
            chk("cdb_result", 64'({cdb_take_branch, cdb_tag, cdb_value}), 64'(exp_r));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   task tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int i, input logic [TAG_W-1:0] t, input logic [XLEN-1:0] v, input logic b);
      fu_valid[i]                 = 1'b1;
      fu_tag[i*TAG_W +: TAG_W]    = t;
      fu_value[i*XLEN +: XLEN]    = v;
      fu_take_branch[i]           = b;
   endtask

   task automatic expect_res(input logic [TAG_W-1:0] t, input logic [XLEN-1:0] v, input logic b);
      sb.push_back({b, t, v});
   endtask

   task idle;
      fu_valid = '0;
   endtask

   task do_reset;
      rst = 1'b0;
      #2;
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; cdb_stall = 1'b0;
      fu_valid = '0; fu_tag = '0; fu_value = '0; fu_take_branch = '0;
      #12;
      chk("rst_valid", 64'(cdb_valid), 64'd0);
      chk("rst_ready", 64'(fu_ready), 64'd7);
      chk("rst_ovf", 64'(overflow_err), 64'd0);
      chk("rst_tag", 64'(cdb_tag), 64'd0);
      chk("rst_value", 64'(cdb_value), 64'd0);
      rst = 1'b1;
      tick;

      // Single result, one-cycle latency then a one-cycle pulse
      drive(0, 5'd1, 32'h0000_000F, 1'b0); expect_res(5'd1, 32'h0000_000F, 1'b0);
      tick; idle;
      tick; chk("single_e1_valid", 64'(cdb_valid), 64'd1);
      tick; chk("single_e2_valid", 64'(cdb_valid), 64'd0);

      // Back-to-back on one FIFO: push and pop every cycle, pointers wrap
      for (int k = 0; k < 4; k++) begin
         drive(0, 5'(11 + k), 32'(32'h100 + k), k[0]);
         expect_res(5'(11 + k), 32'(32'h100 + k), k[0]);
         tick;
         chk("b2b_ready", 64'(fu_ready), 64'd7);
      end
      idle; tick; tick;
      chk("b2b_idle_valid", 64'(cdb_valid), 64'd0);

      // Contention from rr_ptr=0: order 1, 2, 9, then rr_ptr back at 0
      tick; do_reset;
      drive(0, 5'd1, 32'd15, 1'b0);        expect_res(5'd1, 32'd15, 1'b0);
      drive(1, 5'd2, 32'hE000_0000, 1'b1); expect_res(5'd2, 32'hE000_0000, 1'b1);
      drive(2, 5'd9, 32'd6, 1'b0);         expect_res(5'd9, 32'd6, 1'b0);
      tick; idle;
      tick; tick; tick; tick;
      drive(0, 5'd12, 32'hC, 1'b0); drive(2, 5'd13, 32'hD, 1'b1);
      expect_res(5'd12, 32'hC, 1'b0); expect_res(5'd13, 32'hD, 1'b1);
      tick; idle; tick; tick; tick;
      chk("cont_idle_valid", 64'(cdb_valid), 64'd0);

      // Stall holds FU1 result for 3 cycles (rr_ptr=0)
      cdb_stall = 1'b1;
      drive(1, 5'd3, 32'h33, 1'b1); expect_res(5'd3, 32'h33, 1'b1);
      tick; idle;
      chk("stall_valid0", 64'(cdb_valid), 64'd0);
      tick; chk("stall_valid1", 64'(cdb_valid), 64'd0);
      tick; chk("stall_valid2", 64'(cdb_valid), 64'd0);
      cdb_stall = 1'b0;
      tick; chk("stall_release_valid", 64'(cdb_valid), 64'd1);
      tick; chk("stall_after_valid", 64'(cdb_valid), 64'd0);

      // Full FIFO: third push dropped, also while the FIFO is popped (rr_ptr=2)
      cdb_stall = 1'b1;
      drive(2, 5'd4, 32'h44, 1'b0); expect_res(5'd4, 32'h44, 1'b0);
      tick;
      drive(2, 5'd5, 32'h55, 1'b1); expect_res(5'd5, 32'h55, 1'b1);
      tick;
      chk("full_ready", 64'(fu_ready), 64'd3);
      chk("full_ovf_before", 64'(overflow_err), 64'd0);
      drive(2, 5'd6, 32'h66, 1'b0);
      tick;
      chk("full_ovf", 64'(overflow_err), 64'd1);
      chk("full_ready_held", 64'(fu_ready), 64'd3);
      cdb_stall = 1'b0;
      tick; idle;
      tick; tick;
      chk("full_drained_ready", 64'(fu_ready), 64'd7);
      chk("full_idle_valid", 64'(cdb_valid), 64'd0);

      // Flush with 3 buffered plus a concurrent push (rr_ptr=0, overflow_err=1)
      cdb_stall = 1'b1;
      drive(0, 5'd20, 32'h20, 1'b0); drive(1, 5'd21, 32'h21, 1'b0); drive(2, 5'd22, 32'h22, 1'b0);
      tick; idle;
      chk("flush_pre_ready", 64'(fu_ready), 64'd7);
      flush = 1'b1; cdb_stall = 1'b0;
      drive(0, 5'd7, 32'h77, 1'b0);
      tick; flush = 1'b0; idle;
      chk("flush_valid", 64'(cdb_valid), 64'd0);
      chk("flush_ready", 64'(fu_ready), 64'd7);
      chk("flush_ovf_kept", 64'(overflow_err), 64'd1);
      tick; tick; tick;
      drive(2, 5'd23, 32'h23, 1'b1); drive(0, 5'd24, 32'h24, 1'b0);
      expect_res(5'd24, 32'h24, 1'b0); expect_res(5'd23, 32'h23, 1'b1);
      tick; idle; tick; tick; tick;

      // Async reset between edges with cdb_valid high and 2 results buffered
      drive(0, 5'd30, 32'h30, 1'b0); drive(1, 5'd31, 32'h31, 1'b1); drive(2, 5'd32, 32'h32, 1'b0);
      expect_res(5'd30, 32'h30, 1'b0);
      tick; idle;
      tick;
      chk("prereset_valid", 64'(cdb_valid), 64'd1);
      #5;
      rst = 1'b0;
      #1;
      chk("midrst_valid", 64'(cdb_valid), 64'd0);
      chk("midrst_ready", 64'(fu_ready), 64'd7);
      chk("midrst_ovf", 64'(overflow_err), 64'd0);
      chk("midrst_tag", 64'(cdb_tag), 64'd0);
      chk("midrst_value", 64'(cdb_value), 64'd0);
      #1;
      rst = 1'b1;
      drive(1, 5'd10, 32'h50, 1'b0); drive(0, 5'd17, 32'h51, 1'b1);
      expect_res(5'd17, 32'h51, 1'b1); expect_res(5'd10, 32'h50, 1'b0);
      tick; idle; tick; tick; tick; tick;
      chk("end_valid", 64'(cdb_valid), 64'd0);

      for (int w = 0; w < 20 && sb.size() != 0; w++) tick;
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
